// File: rtl/cpu_io_responder.sv
// cpu_io_responder: memory-mapped I/O responder on the CPU's external req/ack bus.
// Handles one read or write per four-phase handshake, with a fixed number of wait
// cycles. It also holds two output registers, a synchronised input port and an edge
// counter on bit 0 of that port.
`timescale 1ns/1ps
module cpu_io_responder #(
   parameter int DW          = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          io_req,
   input  logic          io_we,
   input  logic [1:0]    io_addr,
   input  logic [DW-1:0] io_wdata,
   output logic [DW-1:0] io_rdata,
   output logic          io_ack,
   input  logic [DW-1:0] in_port,
   output logic [DW-1:0] out0,
   output logic [DW-1:0] out1
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_RELEASE
   } state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [1:0]    r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_s1;
   logic [DW-1:0] r_s2;
   logic          r_prev;
   logic [DW-1:0] r_evcnt;
   logic [DW-1:0] r_out0;
   logic [DW-1:0] r_out1;
   logic [DW-1:0] r_rdata;
   logic          r_ack;
   logic [DW-1:0] w_readData;
   logic          w_enterAck;
   logic          w_rise;
   logic          w_clear;

   // The edge that moves WAIT into ACK is where writes commit and read data is captured.
   assign w_enterAck = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_rise     = r_s2[0] & ~r_prev;
   assign w_clear    = w_enterAck & r_we & (r_addr == 2'd3);

   assign io_ack   = r_ack;
   assign io_rdata = r_rdata;
   assign out0     = r_out0;
   assign out1     = r_out1;

   // State register for the handshake sequencer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state: RELEASE waits for io_req to drop so a held request is not served twice.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (io_req) w_next = S_WAIT;
         S_WAIT:    if (r_cnt == 4'd0) w_next = S_ACK;
         S_ACK:     w_next = S_RELEASE;
         S_RELEASE: if (!io_req) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Latch the request fields once at acceptance and count down the wait cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 2'd0;
         r_wdata <= '0;
      end else if (r_state == S_IDLE && io_req) begin
         r_cnt   <= LP_WAIT;
         r_we    <= io_we;
         r_addr  <= io_addr;
         r_wdata <= io_wdata;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Register read mux over the latched address.
   always_comb begin
      w_readData = '0;
      case (r_addr)
         2'd0:    w_readData = r_out0;
         2'd1:    w_readData = r_out1;
         2'd2:    w_readData = r_s2;
         default: w_readData = r_evcnt;
      endcase
   end

   // Ack and read data are registered together and live only for the single ACK cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= w_enterAck;
         r_rdata <= (w_enterAck && !r_we) ? w_readData : '0;
      end
   end

   // Output registers commit on the ACK-entry edge; writes to IN are silently dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out0 <= '0;
         r_out1 <= '0;
      end else if (w_enterAck && r_we) begin
         if (r_addr == 2'd0) r_out0 <= r_wdata;
         if (r_addr == 2'd1) r_out1 <= r_wdata;
      end
   end

   // Two-flop synchroniser for the asynchronous pins, plus a delayed bit 0 for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= in_port;
         r_s2   <= r_s1;
         r_prev <= r_s2[0];
      end
   end

   // Edge counter: a clear that coincides with a rising edge still counts that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       r_evcnt <= '0;
      else if (w_clear) r_evcnt <= {{(DW-1){1'b0}}, w_rise};
      else              r_evcnt <= r_evcnt + {{(DW-1){1'b0}}, w_rise};
   end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Self-checking bench for cpu_io_responder: directed steps followed by randomized
// transactions, compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cpu_io_responder;

   localparam int WS = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       io_req;
   logic       reqW0;
   logic       reqW3;
   logic       io_we;
   logic [1:0] io_addr;
   logic [7:0] io_wdata;
   logic [7:0] in_port;
   logic [7:0] io_rdata;
   logic       io_ack;
   logic [7:0] out0;
   logic [7:0] out1;
   logic [7:0] rdW0, out0W0, out1W0, rdW3, out0W3, out1W3;
   logic       ackW0, ackW3;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: register contents, pin history (newest first) and event count.
   logic [7:0] mOut0, mOut1, mEv, expRd;
   logic [7:0] hist[$];
   logic       tWe;
   logic [1:0] tAddr;
   logic [7:0] tData;
   bit         randPins = 0;

   always #5 clk = ~clk;

   cpu_io_responder #(.DW(8), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .reset(reset), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack), .in_port(in_port),
      .out0(out0), .out1(out1));

   cpu_io_responder #(.DW(8), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .io_req(reqW0), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(rdW0), .io_ack(ackW0), .in_port(in_port),
      .out0(out0W0), .out1(out1W0));

   cpu_io_responder #(.DW(8), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset(reset), .io_req(reqW3), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(rdW3), .io_ack(ackW3), .in_port(in_port),
      .out0(out0W3), .out1(out1W3));

   // Pin value sampled k edges ago; anything older than the last reset reads as 0.
   function automatic logic [7:0] histVal(input int k);
      return (k < hist.size()) ? hist[k] : 8'h00;
   endfunction

   function automatic logic auxAck(input int which);
      return (which == 0) ? ackW0 : ackW3;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; the model advances and, on a commit edge, applies the latched transaction.
   task automatic tick(input bit commit);
      logic rise;
      logic clr;
      @(posedge clk);
      if (reset === 1'b0) begin
         hist.delete();
         mOut0 = 8'h00;
         mOut1 = 8'h00;
         mEv   = 8'h00;
      end else begin
         hist.push_front(in_port);
         if (hist.size() > 8) void'(hist.pop_back());
         // The counter sees pins two edges late; a rise is a 0 then 1 in that delayed view.
         rise = histVal(2)[0] && !histVal(3)[0];
         clr  = 1'b0;
         if (commit) begin
            if (tWe) begin
               if (tAddr == 2'd0) mOut0 = tData;
               if (tAddr == 2'd1) mOut1 = tData;
               if (tAddr == 2'd3) clr = 1'b1;
            end else begin
               case (tAddr)
                  2'd0:    expRd = mOut0;
                  2'd1:    expRd = mOut1;
                  2'd2:    expRd = histVal(2);
                  default: expRd = mEv;
               endcase
            end
         end
         mEv = clr ? {7'd0, rise} : mEv + {7'd0, rise};
      end
      #1;
      if (randPins) in_port = 8'($urandom);
   endtask

   // Full four-phase transaction on the main instance with cycle-by-cycle checks.
   task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                                input bit dropEarly, output logic [7:0] rdObs);
      io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
      tWe = we; tAddr = addr; tData = wdata;
      tick(0);
      io_we = 1'($urandom); io_addr = 2'($urandom); io_wdata = 8'($urandom);
      if (dropEarly) io_req = 1'b0;
      for (int n = 1; n <= WS; n++) begin
         tick(0);
         checkOutput("ack_before", {31'd0, io_ack}, 32'd0);
         checkOutput("rdata_before", {24'd0, io_rdata}, 32'd0);
         checkOutput("out0_before", {24'd0, out0}, {24'd0, mOut0});
         checkOutput("out1_before", {24'd0, out1}, {24'd0, mOut1});
      end
      tick(1);
      checkOutput("ack_pulse", {31'd0, io_ack}, 32'd1);
      rdObs = io_rdata;
      if (!we) checkOutput("rdata", {24'd0, io_rdata}, {24'd0, expRd});
      checkOutput("out0", {24'd0, out0}, {24'd0, mOut0});
      checkOutput("out1", {24'd0, out1}, {24'd0, mOut1});
      tick(0);
      checkOutput("ack_fall", {31'd0, io_ack}, 32'd0);
      checkOutput("rdata_fall", {24'd0, io_rdata}, 32'd0);
      io_req = 1'b0;
      tick(0);
      checkOutput("ack_release", {31'd0, io_ack}, 32'd0);
   endtask

   // Latency of an auxiliary instance, and no second ack while the request stays high.
   task automatic checkLatency(input int which, input int ws);
      int n;
      int extra;
      for (int round = 0; round < 2; round++) begin
         if (which == 0) reqW0 = 1'b1; else reqW3 = 1'b1;
         tick(0);
         n = 0;
         while (auxAck(which) == 1'b0 && n < 20) begin
            tick(0);
            n++;
         end
         checkOutput((which == 0) ? "latency_ws0" : "latency_ws3", n, ws + 1);
         extra = 0;
         for (int i = 0; i < 6; i++) begin
            tick(0);
            if (auxAck(which)) extra++;
         end
         checkOutput("no_second_ack", extra, 0);
         if (which == 0) reqW0 = 1'b0; else reqW3 = 1'b0;
         tick(0);
      end
   endtask

   initial begin
      logic [7:0] rd;
      reset = 1'b0; io_req = 1'b0; reqW0 = 1'b0; reqW3 = 1'b0;
      io_we = 1'b0; io_addr = 2'd0; io_wdata = 8'h00; in_port = 8'h00;
      mOut0 = 8'h00; mOut1 = 8'h00; mEv = 8'h00; expRd = 8'h00;
      tWe = 1'b0; tAddr = 2'd0; tData = 8'h00;

      // Reset held with random activity on every input.
      for (int i = 0; i < 4; i++) begin
         tick(0);
         io_req = 1'($urandom); io_we = 1'($urandom); io_addr = 2'($urandom);
         io_wdata = 8'($urandom); in_port = 8'($urandom);
         #2;
         checkOutput("reset_ack", {31'd0, io_ack}, 32'd0);
         checkOutput("reset_rdata", {24'd0, io_rdata}, 32'd0);
         checkOutput("reset_out0", {24'd0, out0}, 32'd0);
         checkOutput("reset_out1", {24'd0, out1}, 32'd0);
      end
      io_req = 1'b0; in_port = 8'h00;
      tick(0);
      reset = 1'b1;
      tick(0);
      applyStimulus(1'b0, 2'd3, 8'h00, 1'b0, rd);
      checkOutput("reset_evcnt", {24'd0, rd}, 32'd0);

      // Basic write then read back.
      applyStimulus(1'b1, 2'd0, 8'hA5, 1'b0, rd);
      checkOutput("t2_out0", {24'd0, out0}, 32'hA5);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, rd);
      checkOutput("t2_read0", {24'd0, rd}, 32'hA5);

      // Latency for zero and three wait states.
      checkLatency(0, 0);
      checkLatency(3, 3);

      // Pin to readable in two edges: the read captures the pin sampled at acceptance.
      for (int i = 0; i < 4; i++) tick(0);
      in_port = 8'h01;
      applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, rd);
      checkOutput("in_latency", {24'd0, rd}, 32'h01);

      // 300 rising edges wrap the counter to 44.
      in_port = 8'h00;
      for (int i = 0; i < 4; i++) tick(0);
      applyStimulus(1'b1, 2'd3, 8'h77, 1'b0, rd);
      for (int i = 0; i < 600; i++) begin
         in_port = (i % 2 == 1) ? 8'h01 : 8'h00;
         tick(0);
      end
      in_port = 8'h00;
      for (int i = 0; i < 4; i++) tick(0);
      applyStimulus(1'b0, 2'd3, 8'h00, 1'b0, rd);
      checkOutput("evcnt_wrap", {24'd0, rd}, 32'd44);

      // Clear landing on the same edge as a counted rise leaves the count at 1.
      in_port = 8'h01;
      applyStimulus(1'b1, 2'd3, 8'hFF, 1'b0, rd);
      applyStimulus(1'b0, 2'd3, 8'h00, 1'b0, rd);
      checkOutput("evcnt_clear_rise", {24'd0, rd}, 32'd1);

      // Write to IN is acked and ignored.
      in_port = 8'h5A;
      for (int i = 0; i < 3; i++) tick(0);
      applyStimulus(1'b1, 2'd2, 8'hFF, 1'b0, rd);
      applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, rd);
      checkOutput("in_unchanged", {24'd0, rd}, 32'h5A);

      // Request dropped while waiting still completes with a single ack.
      applyStimulus(1'b1, 2'd1, 8'h96, 1'b1, rd);
      checkOutput("drop_out1", {24'd0, out1}, 32'h96);

      // Reset during WAIT of a write aborts it: no ack, no commit.
      applyStimulus(1'b1, 2'd1, 8'h00, 1'b0, rd);
      io_req = 1'b1; io_we = 1'b1; io_addr = 2'd1; io_wdata = 8'h3C;
      tick(0);
      #2;
      reset = 1'b0;
      #1;
      io_req = 1'b0;
      checkOutput("abort_ack", {31'd0, io_ack}, 32'd0);
      checkOutput("abort_out1", {24'd0, out1}, 32'd0);
      tick(0);
      tick(0);
      reset = 1'b1;
      begin
         int acks = 0;
         for (int i = 0; i < 5; i++) begin
            tick(0);
            if (io_ack) acks++;
         end
         checkOutput("abort_no_ack", acks, 0);
         checkOutput("abort_out1_after", {24'd0, out1}, 32'd0);
      end

      // Randomized transactions with the pins changing every cycle.
      randPins = 1;
      for (int t = 0; t < 60; t++) begin
         applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), rd);
         if ($urandom_range(0, 2) == 0) tick(0);
      end
      randPins = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
